// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver
//   Sink-side checker for the 640x480@60 VGA timing generator. It recovers
//   pixel coordinates from the sync/blank stream and checks line, frame and
//   active-window geometry. It declares lock after LOCK_FRAMES consecutive
//   clean frames.
//
//   Ports
//     clk_25       pixel clock
//     rst          asynchronous reset, active-high
//     vga_hsync    horizontal sync, active-low
//     vga_vsync    vertical sync, active-low
//     sync_blank   1 = active video
//     clr_err      synchronous clear of err_flags (a same-cycle violation wins)
//     px_x, px_y   active pixel column/row, held when pixel_valid is low
//     pixel_valid  px_x/px_y qualify a visible pixel (only while locked)
//     line_start   pulse on pixel 0 of each active line
//     frame_start  pulse on pixel (0,0)
//     locked       timing verified
//     timing_err   one-cycle pulse per cycle with a detected violation
//     err_flags    sticky: [0] line length, [1] frame length,
//                          [2] active width, [3] active height
//
//   Interface semantics: there is no backpressure. pixel_valid is a pure
//   qualifier: a pixel is presented for exactly one clk_25 cycle when
//   pixel_valid is high, and px_x/px_y carry its coordinates in that cycle.
//
//   Pipeline: stage 1 registers the pins, edges compare stage 1 with its
//   previous value, stage 2 registers every output -> 2 clocks pin-to-output.
module vga_timing_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic       vga_hsync,
  input  logic       vga_vsync,
  input  logic       sync_blank,
  input  logic       clr_err,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       pixel_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err,
  output logic [3:0] err_flags
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [9:0] CNT_MAX = 10'h3ff;

  // Stage 1: input registers and their previous values (reset to idle levels).
  logic hs_q, vs_q, bl_q;
  logic hs_d, vs_d, bl_d;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      bl_q <= 1'b0;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      bl_d <= 1'b0;
    end else begin
      hs_q <= vga_hsync;
      vs_q <= vga_vsync;
      bl_q <= sync_blank;
      hs_d <= hs_q;
      vs_d <= vs_q;
      bl_d <= bl_q;
    end
  end

  logic hfall, vfall, blfall;
  assign hfall  = hs_d & ~hs_q;
  assign vfall  = vs_d & ~vs_q;
  assign blfall = bl_d & ~bl_q;

  // Geometry counters.
  logic [9:0] h_cnt, v_cnt, ax, ay;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      ax    <= '0;
      ay    <= '0;
    end else begin
      if (hfall)                  h_cnt <= '0;
      else if (h_cnt != CNT_MAX)  h_cnt <= h_cnt + 10'd1;

      if (vfall)                           v_cnt <= '0;
      else if (hfall && v_cnt != CNT_MAX)  v_cnt <= v_cnt + 10'd1;

      if (!bl_q)                 ax <= '0;
      else if (ax != CNT_MAX)    ax <= ax + 10'd1;

      if (vfall)                            ay <= '0;
      else if (blfall && ay != CNT_MAX)     ay <= ay + 10'd1;
    end
  end

  logic [1:0] state, state_nxt;
  logic [7:0] good_cnt, good_nxt;
  logic       viol_seen;

  // An hsync/blank edge coinciding with vfall belongs to the frame that is
  // ending, so it is folded into that frame's measurement before the clear.
  logic [10:0] h_meas, v_meas, a_meas;
  assign h_meas = {1'b0, h_cnt} + 11'd1;
  assign v_meas = {1'b0, v_cnt} + {10'd0, hfall};
  assign a_meas = {1'b0, ay} + {10'd0, blfall};

  logic       chk_en, sync_lost, any_viol;
  logic [3:0] viol;

  assign chk_en    = (state == ST_MEASURE) || (state == ST_LOCKED);
  // A saturated h_cnt means hsync has gone away; this is loss of signal,
  // not a geometry error, so it only forces a re-search.
  assign sync_lost = (h_cnt == CNT_MAX);

  assign viol[0] = chk_en & hfall  & (h_meas != 11'(H_TOTAL));
  assign viol[1] = chk_en & vfall  & (v_meas != 11'(V_TOTAL));
  assign viol[2] = chk_en & blfall & (ax != 10'(H_ACTIVE));
  assign viol[3] = chk_en & vfall  & (a_meas != 11'(V_ACTIVE));
  assign any_viol = |viol;

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    case (state)
      ST_SEARCH: begin
        if (vfall) begin
          state_nxt = ST_MEASURE;
          good_nxt  = '0;
        end
      end
      ST_MEASURE: begin
        if (vfall) begin
          if (viol_seen || any_viol) begin
            good_nxt = '0;
          end else begin
            good_nxt = good_cnt + 8'd1;
            if (good_cnt + 8'd1 >= 8'(LOCK_FRAMES)) state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (any_viol) begin
          state_nxt = ST_MEASURE;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
        good_nxt  = '0;
      end
    endcase
    if (sync_lost) begin
      state_nxt = ST_SEARCH;
      good_nxt  = '0;
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state     <= ST_SEARCH;
      good_cnt  <= '0;
      viol_seen <= 1'b0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      // Tracks violations within the current vfall-to-vfall window.
      if (vfall)          viol_seen <= 1'b0;
      else if (any_viol)  viol_seen <= 1'b1;
    end
  end

  // Stage 2: registered outputs.
  logic px_ok;
  assign px_ok = bl_q && (state == ST_LOCKED);

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      px_x        <= '0;
      px_y        <= '0;
      pixel_valid <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      err_flags   <= '0;
    end else begin
      pixel_valid <= px_ok;
      if (px_ok) begin
        px_x <= ax;
        px_y <= ay;
      end
      line_start  <= px_ok && (ax == 10'd0);
      frame_start <= px_ok && (ax == 10'd0) && (ay == 10'd0);
      locked      <= (state_nxt == ST_LOCKED);
      timing_err  <= any_viol;
      err_flags   <= (clr_err ? 4'b0000 : err_flags) | viol;
    end
  end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver using a scaled-down raster (40x40 clocks,
// 24x24 active) so that many frames fit in a short run.
module tb_vga_timing_receiver;

  localparam int H_T      = 40;
  localparam int H_A      = 24;
  localparam int HS_START = 28;
  localparam int HS_END   = 34;   // hsync low for 6 clocks
  localparam int V_T      = 40;
  localparam int V_A      = 24;
  localparam int VS_LINE  = 32;   // vsync low for one whole line
  localparam int HOLD     = 1100;
  localparam int NONE     = -1;

  // ---------------- clock / reset ----------------
  logic       clk_25 = 1'b0;
  logic       rst = 1'b0;
  logic       vga_hsync, vga_vsync, sync_blank, clr_err;
  logic [9:0] px_x, px_y;
  logic       pixel_valid, line_start, frame_start, locked, timing_err;
  logic [3:0] err_flags;

  always #5 clk_25 = ~clk_25;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk_25) cyc <= cyc + 32'd1;

  vga_timing_receiver #(
    .H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACTIVE(H_A), .V_ACTIVE(V_A), .LOCK_FRAMES(2)
  ) dut (
    .clk_25(clk_25), .rst(rst), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .sync_blank(sync_blank), .clr_err(clr_err), .px_x(px_x), .px_y(px_y),
    .pixel_valid(pixel_valid), .line_start(line_start), .frame_start(frame_start),
    .locked(locked), .timing_err(timing_err), .err_flags(err_flags)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // record: {expected output cycle[31:0], frame_start, line_start, x[9:0], y[9:0]}
  localparam int W = 54;
  logic [W-1:0] exp_q[$];
  logic         sb_on = 1'b0;
  int           pix_cnt = 0;
  int           ls_cnt = 0;
  int           terr_cnt = 0;

  always @(negedge clk_25) begin
    logic [W-1:0] rec;
    if (timing_err === 1'b1) terr_cnt++;
    if (sb_on && pixel_valid === 1'b1) begin
      pix_cnt++;
      if (line_start === 1'b1) ls_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        rec = exp_q.pop_front();
        chk("sb_cycle", cyc, rec[53:22]);
        chk("sb_frame_start", 32'(frame_start), 32'(rec[21]));
        chk("sb_line_start", 32'(line_start), 32'(rec[20]));
        chk("sb_px_x", 32'(px_x), 32'(rec[19:10]));
        chk("sb_px_y", 32'(px_y), 32'(rec[9:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  int   hold_left = 0;
  logic clr_req = 1'b0;

  task automatic drive_px(input int h, input int v, input logic bl, input logic do_rst);
    if (hold_left > 0) begin
      vga_hsync = 1'b1;
      hold_left--;
    end else begin
      vga_hsync = !(h >= HS_START && h < HS_END);
    end
    vga_vsync  = !(v == VS_LINE);
    sync_blank = bl;
    clr_err    = clr_req;
    clr_req    = 1'b0;
    if (sb_on && bl)
      exp_q.push_back({cyc + 32'd2, (h == 0 && v == 0), (h == 0), 10'(h), 10'(v)});
    if (do_rst) begin
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_pixel_valid", 32'(pixel_valid), 32'd0);
      chk("rst_mid_px_x", 32'(px_x), 32'd0);
      chk("rst_mid_px_y", 32'(px_y), 32'd0);
      chk("rst_mid_line_start", 32'(line_start), 32'd0);
      chk("rst_mid_frame_start", 32'(frame_start), 32'd0);
      chk("rst_mid_locked", 32'(locked), 32'd0);
      chk("rst_mid_timing_err", 32'(timing_err), 32'd0);
      chk("rst_mid_err_flags", 32'(err_flags), 32'd0);
    end
    @(posedge clk_25);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_frame(input int stretch_ln, input int short_ln, input int n_lines,
                           input int hold_ln, input int rst_ln);
    for (int v = 0; v < n_lines; v++) begin
      for (int h = 0; h < H_T; h++) begin
        int run_len;
        run_len = (v == short_ln) ? H_A - 1 : H_A;
        if (v == hold_ln && h == 0) hold_left = HOLD;
        drive_px(h, v, (v < V_A) && (h < run_len), (v == rst_ln) && (h == 10));
        if (v == stretch_ln && h == H_T - 1) drive_px(h, v, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic clean_frame();
    run_frame(NONE, NONE, V_T, NONE, NONE);
  endtask

  // ---------------- directed sequence ----------------
  int t0;

  initial begin
    vga_hsync  = 1'b1;
    vga_vsync  = 1'b1;
    sync_blank = 1'b0;
    clr_err    = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk_25);
    #1;
    chk("reset_pixel_valid", 32'(pixel_valid), 32'd0);
    chk("reset_px_x", 32'(px_x), 32'd0);
    chk("reset_px_y", 32'(px_y), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_timing_err", 32'(timing_err), 32'd0);
    chk("reset_err_flags", 32'(err_flags), 32'd0);
    rst = 1'b0;

    // Ideal timing from reset: lock after the 3rd vfall.
    clean_frame();
    clean_frame();
    chk("t1_unlocked_after_2_vfalls", 32'(locked), 32'd0);
    clean_frame();
    chk("t1_locked_after_3_vfalls", 32'(locked), 32'd1);
    chk("t1_err_flags", 32'(err_flags), 32'd0);
    chk("t1_no_timing_err", 32'(terr_cnt), 32'd0);

    // Locked frame through the scoreboard: coordinates, pulses, 2-clock latency.
    pix_cnt = 0;
    ls_cnt  = 0;
    sb_on   = 1'b1;
    clean_frame();
    sb_on   = 1'b0;
    chk("t2_sb_drained", 32'(exp_q.size()), 32'd0);
    chk("t2_pixel_count", 32'(pix_cnt), 32'(H_A * V_A));
    chk("t2_line_starts", 32'(ls_cnt), 32'(V_A));
    chk("t2_final_px_x", 32'(px_x), 32'(H_A - 1));
    chk("t2_final_px_y", 32'(px_y), 32'(V_A - 1));

    // One line stretched by one clock.
    t0 = terr_cnt;
    run_frame(3, NONE, V_T, NONE, NONE);
    chk("t3_one_pulse", 32'(terr_cnt - t0), 32'd1);
    chk("t3_err_flags", 32'(err_flags), 32'b0001);
    chk("t3_unlocked", 32'(locked), 32'd0);
    clean_frame();
    chk("t3_unlocked_1_clean", 32'(locked), 32'd0);
    clean_frame();
    chk("t3_relocked", 32'(locked), 32'd1);
    clr_req = 1'b1;
    clean_frame();
    chk("t3_clr_err", 32'(err_flags), 32'd0);
    chk("t3_still_locked", 32'(locked), 32'd1);

    // One active run one pixel short.
    t0 = terr_cnt;
    run_frame(NONE, 3, V_T, NONE, NONE);
    chk("t4_width_flag", 32'(err_flags), 32'b0100);
    chk("t4_width_unlocked", 32'(locked), 32'd0);
    chk("t4_width_pulse", 32'(terr_cnt - t0), 32'd1);
    clean_frame();
    clean_frame();
    chk("t4_width_relocked", 32'(locked), 32'd1);

    // A frame one line short, seen at the following vfall.
    clr_req = 1'b1;
    run_frame(NONE, NONE, V_T - 1, NONE, NONE);
    chk("t4_flags_cleared", 32'(err_flags), 32'd0);
    t0 = terr_cnt;
    clean_frame();
    chk("t4_frame_flag", 32'(err_flags), 32'b0010);
    chk("t4_frame_unlocked", 32'(locked), 32'd0);
    chk("t4_frame_pulse", 32'(terr_cnt - t0), 32'd1);
    clean_frame();
    chk("t4_frame_unlocked_1_clean", 32'(locked), 32'd0);
    clean_frame();
    chk("t4_frame_relocked", 32'(locked), 32'd1);

    // hsync held high long enough to saturate h_cnt: lost sync, no error.
    clr_req = 1'b1;
    t0 = terr_cnt;
    run_frame(NONE, NONE, V_T, 1, NONE);
    chk("t5_unlocked", 32'(locked), 32'd0);
    chk("t5_no_err_flag", 32'(err_flags), 32'd0);
    chk("t5_no_pulse", 32'(terr_cnt - t0), 32'd0);
    clean_frame();
    chk("t5_unlocked_2nd_vfall", 32'(locked), 32'd0);
    clean_frame();
    chk("t5_relocked", 32'(locked), 32'd1);
    chk("t5_err_flags_final", 32'(err_flags), 32'd0);

    // Reset asserted in the middle of an active line.
    t0 = terr_cnt;
    run_frame(NONE, NONE, V_T, NONE, 5);
    chk("t6_unlocked_1st_vfall", 32'(locked), 32'd0);
    clean_frame();
    chk("t6_unlocked_2nd_vfall", 32'(locked), 32'd0);
    clean_frame();
    chk("t6_relocked", 32'(locked), 32'd1);
    chk("t6_err_flags", 32'(err_flags), 32'd0);
    chk("t6_no_pulse", 32'(terr_cnt - t0), 32'd0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
